// File: rtl/clc_pow.sv
// clc_pow: sequential square-and-multiply exponentiator producing g^x (64-bit) with overflow flag.
// Optional build macro CLC_POW_SAT_EN: saturate exp to all-ones when the true result overflows.
module clc_pow #(
   parameter int unsigned X_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [31:0]    g,
   input  logic [X_W-1:0] x,
   input  logic           start,
   output logic [63:0]    exp,
   output logic           st,
   output logic           busy,
   output logic           ovf
);

`ifdef CLC_POW_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [63:0]    acc_q, acc_d;
   logic [63:0]    base_q, base_d;
   logic [X_W-1:0] e_q, e_d;
   logic           base_ovf_q, base_ovf_d;
   logic           acc_ovf_q, acc_ovf_d;
   logic [63:0]    exp_q, exp_d;
   logic           ovf_q, ovf_d;

   logic [127:0]   acc_prod, sq_prod;
   logic [63:0]    acc_nxt;
   logic           acc_ovf_nxt;
   logic [X_W-1:0] e_shr;

   assign acc_prod = {64'b0, acc_q} * {64'b0, base_q};
   assign sq_prod  = {64'b0, base_q} * {64'b0, base_q};
   assign e_shr    = e_q >> 1;

   // A product built on an already-overflowed base overflows too, since acc >= 1.
   assign acc_nxt     = e_q[0] ? acc_prod[63:0] : acc_q;
   assign acc_ovf_nxt = acc_ovf_q | (e_q[0] & ((|acc_prod[127:64]) | base_ovf_q));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         base_q     <= '0;
         e_q        <= '0;
         base_ovf_q <= 1'b0;
         acc_ovf_q  <= 1'b0;
         exp_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         base_q     <= base_d;
         e_q        <= e_d;
         base_ovf_q <= base_ovf_d;
         acc_ovf_q  <= acc_ovf_d;
         exp_q      <= exp_d;
         ovf_q      <= ovf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      base_d     = base_q;
      e_d        = e_q;
      base_ovf_d = base_ovf_q;
      acc_ovf_d  = acc_ovf_q;
      exp_d      = exp_q;
      ovf_d      = ovf_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = RUN;
               acc_d      = 64'd1;
               base_d     = {32'b0, g};
               e_d        = x;
               base_ovf_d = 1'b0;
               acc_ovf_d  = 1'b0;
               ovf_d      = 1'b0;
            end
         end
         RUN: begin
            if (e_q == '0) begin
               state_d = DONE;
               exp_d   = acc_q;
               ovf_d   = 1'b0;
            end else begin
               acc_d      = acc_nxt;
               acc_ovf_d  = acc_ovf_nxt;
               base_d     = sq_prod[63:0];
               base_ovf_d = base_ovf_q | (|sq_prod[127:64]);
               e_d        = e_shr;
               // Final square is discarded; only acc_ovf feeds the reported flag.
               if (e_shr == '0) begin
                  state_d = DONE;
                  exp_d   = (SAT_EN && acc_ovf_nxt) ? '1 : acc_nxt;
                  ovf_d   = acc_ovf_nxt;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign exp  = exp_q;
   assign st   = (state_q == DONE);
   assign busy = (state_q == RUN);
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_clc_pow.sv
// Self-checking bench for clc_pow: directed plan cases plus randomized runs against a repeated-multiply model.
// Honours CLC_POW_SAT_EN the same way as the design.
module tb_clc_pow;
   localparam int unsigned X_W = 32;

   logic           clk;
   logic           rst;
   logic [31:0]    g;
   logic [X_W-1:0] x;
   logic           start;
   logic [63:0]    exp;
   logic           st;
   logic           busy;
   logic           ovf;

   int n_tests;
   int n_fail;

   clc_pow #(.X_W(X_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .g     (g),
      .x     (x),
      .start (start),
      .exp   (exp),
      .st    (st),
      .busy  (busy),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
      n_tests++;
      if (obs !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, req);
      end
   endtask

   // Reference: g^x by plain repeated multiplication; overflow tracked on the exact value.
   function automatic void model(input logic [31:0] gi, input logic [31:0] xi,
                                 output logic [63:0] r, output logic o);
      logic [63:0]  low;
      logic [127:0] tv;
      logic         big;
      low = 64'd1;
      tv  = 128'd1;
      big = 1'b0;
      if (xi == 0) begin
         low = 64'd1;
      end else if (gi == 0) begin
         low = 64'd0;
      end else if (gi == 1) begin
         low = 64'd1;
      end else if (gi == 2) begin
         low = (xi < 64) ? (64'd1 << xi) : 64'd0;
         big = (xi >= 64);
      end else begin
         for (int unsigned i = 0; i < xi; i++) begin
            low = low * {32'b0, gi};
            if (!big) begin
               tv  = tv * {96'b0, gi};
               big = (tv[127:64] != 0);
            end
         end
      end
`ifdef CLC_POW_SAT_EN
      r = big ? 64'hFFFF_FFFF_FFFF_FFFF : low;
`else
      r = low;
`endif
      o = big;
   endfunction

   function automatic int exp_latency(input logic [31:0] xi);
      int b;
      b = 1;
      for (int i = 0; i < 32; i++) if (xi[i]) b = i + 1;
      return b;
   endfunction

   // Entered and left #1 after a rising edge. restart_at >= 0 raises start before that RUN edge.
   task automatic run_op(input string nm, input logic [31:0] gi, input logic [31:0] xi,
                         input int restart_at);
      int          n;
      logic        bad;
      logic [63:0] r;
      logic        o;
      g = gi;
      x = xi;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({nm, "/st_drop"}, {63'b0, st}, 64'd0);
      n = 0;
      bad = 1'b0;
      while (st !== 1'b1 && n < int'(X_W) + 4) begin
         if (busy !== 1'b1 || st !== 1'b0) bad = 1'b1;
         start = (n == restart_at);
         g = $urandom;
         x = $urandom;
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      model(gi, xi, r, o);
      check({nm, "/busy_run"}, {63'b0, bad}, 64'd0);
      check({nm, "/latency"}, 64'(n), 64'(exp_latency(xi)));
      check({nm, "/exp"}, exp, r);
      check({nm, "/ovf"}, {63'b0, ovf}, {63'b0, o});
      check({nm, "/busy_done"}, {63'b0, busy}, 64'd0);
      @(posedge clk); #1;
      check({nm, "/st_hold"}, {62'b0, st, busy}, 64'd2);
      check({nm, "/exp_hold"}, exp, r);
   endtask

   initial begin
      logic [31:0] rg, rx;
      n_tests = 0;
      n_fail  = 0;
      rst   = 1'b0;
      start = 1'b0;
      g     = '0;
      x     = '0;
      #12;
      check("reset", {exp, 4'b0} >> 4 | {60'b0, st, busy, ovf, 1'b0}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("idle", {61'b0, st, busy, ovf}, 64'd0);

      run_op("g5x3", 32'd5, 32'd3, -1);
      run_op("g7x0", 32'd7, 32'd0, -1);
      run_op("g0x7", 32'd0, 32'd7, -1);
      run_op("g2x63", 32'd2, 32'd63, -1);
      run_op("g2x64", 32'd2, 32'd64, -1);
      run_op("g1xmsb", 32'd1, 32'h8000_0000, -1);
      run_op("g3x255_restart", 32'd3, 32'd255, 2);
      run_op("exit_start", 32'd5, 32'd3, 1);
      run_op("g9x1", 32'd9, 32'd1, -1);

      // Asynchronous reset in the middle of a long run.
      g = 32'd3; x = 32'd255; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("rst_mid_exp", exp, 64'd0);
      check("rst_mid_flags", {61'b0, st, busy, ovf}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      run_op("after_rst", 32'd5, 32'd3, -1);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0: begin rg = $urandom_range(0, 1);  rx = $urandom; end
            1: begin rg = 32'd2;                 rx = $urandom_range(0, 80); end
            2: begin rg = $urandom;              rx = $urandom_range(0, 3); end
            3: begin rg = $urandom_range(3, 20); rx = $urandom_range(0, 40); end
            default: begin rg = $urandom;        rx = $urandom_range(0, 200); end
         endcase
         run_op("rand", rg, rx, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end
endmodule
